// File: rtl/sync_fifo_pkg.sv
// Shared constants for sync_fifo instantiations in the tracer pipeline:
// default geometry, depth/count-width helpers and default flag thresholds.
package sync_fifo_pkg;

  localparam int FIFO_DEF_DATA_W     = 8;
  localparam int FIFO_DEF_ADDR_W     = 4;
  localparam int FIFO_DEF_AEMPTY_LVL = 2;

  function automatic int fifo_depth(input int addr_w);
    return 32'sd1 << addr_w;
  endfunction

  function automatic int fifo_count_w(input int addr_w);
    return addr_w + 32'sd1;
  endfunction

  // Almost-full default leaves two slots of headroom for in-flight producers.
  function automatic int fifo_def_afull(input int addr_w);
    return fifo_depth(addr_w) - 32'sd2;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The array itself is never reset; only the read data register is.
module sdp_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [2**ADDR_W];
  logic [DATA_W-1:0] rdata_r;

  // write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // registered read; holds the last word when no read is requested
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r <= {DATA_W{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, threshold flags and synchronous flush.
// Optional sticky overflow/underflow capture is enabled by FIFO_ERR_FLAGS_EN.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W     = FIFO_DEF_DATA_W,
  parameter int ADDR_W     = FIFO_DEF_ADDR_W,
  parameter int AFULL_LVL  = fifo_def_afull(ADDR_W),
  parameter int AEMPTY_LVL = FIFO_DEF_AEMPTY_LVL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] PTR_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] DEPTH_C  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AFULL_C  = AFULL_LVL[ADDR_W:0];
  localparam logic [ADDR_W:0] AEMPTY_C = AEMPTY_LVL[ADDR_W:0];

  logic [ADDR_W:0] wptr_r;
  logic [ADDR_W:0] rptr_r;
  logic [ADDR_W:0] count_r;
  logic            dout_valid_r;
  logic            full_s;
  logic            empty_s;
  logic            push_ok_s;
  logic            pop_ok_s;
  logic            wr_en_s;
  logic            rd_en_s;

  assign full_s    = (count_r == DEPTH_C);
  assign empty_s   = (count_r == PTR_ZERO);
  assign push_ok_s = push && !full_s;
  assign pop_ok_s  = pop && !empty_s;
  // flush suppresses both RAM ports so its cycle has no side effects
  assign wr_en_s   = push_ok_s && !flush;
  assign rd_en_s   = pop_ok_s && !flush;

  sdp_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_en_s),
    .waddr(wptr_r[ADDR_W-1:0]),
    .wdata(din),
    .re   (rd_en_s),
    .raddr(rptr_r[ADDR_W-1:0]),
    .rdata(dout)
  );

  // pointer, occupancy and read-valid state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_r       <= PTR_ZERO;
      rptr_r       <= PTR_ZERO;
      count_r      <= PTR_ZERO;
      dout_valid_r <= 1'b0;
    end else if (flush) begin
      wptr_r       <= PTR_ZERO;
      rptr_r       <= PTR_ZERO;
      count_r      <= PTR_ZERO;
      dout_valid_r <= 1'b0;
    end else begin
      wptr_r       <= push_ok_s ? (wptr_r + PTR_ONE) : wptr_r;
      rptr_r       <= pop_ok_s ? (rptr_r + PTR_ONE) : rptr_r;
      dout_valid_r <= pop_ok_s;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + PTR_ONE;
        2'b01:   count_r <= count_r - PTR_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout_valid   = dout_valid_r;
  assign count        = count_r;
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (count_r >= AFULL_C);
  assign almost_empty = (count_r <= AEMPTY_C);

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_r;
  logic underflow_r;

  // sticky error capture; clr_err beats a same-cycle set, flush leaves flags alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (clr_err) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= overflow_r  || (push && full_s  && !flush);
      underflow_r <= underflow_r || (pop  && empty_s && !flush);
    end
  end

  assign overflow  = overflow_r;
  assign underflow = underflow_r;
`else
  logic unused_clr_err_s;
  assign unused_clr_err_s = clr_err;
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (default geometry: 8-bit words, 16 deep).
module tb_sync_fifo;

`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       push = 1'b0;
  logic [7:0] din = 8'h00;
  logic       pop = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic [4:0] count;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;

  int n_checks = 0;
  int n_pass   = 0;

  sync_fifo dut (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .din(din), .pop(pop),
    .dout(dout), .dout_valid(dout_valid), .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       flush;
    logic       push;
    logic [7:0] din;
    logic       pop;
    logic       clr_err;
    int         exp_cnt;
    logic       exp_valid;
    logic [7:0] exp_dout;
    logic       exp_udf;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // occupancy plus every flag derived from the expected count
  task automatic chk_state(input string name, input int exp_cnt);
    chk({name, ".count"}, {27'd0, count}, exp_cnt);
    chk({name, ".empty"}, {31'd0, empty}, {31'd0, exp_cnt == 0});
    chk({name, ".full"}, {31'd0, full}, {31'd0, exp_cnt == 16});
    chk({name, ".afull"}, {31'd0, almost_full}, {31'd0, exp_cnt >= 14});
    chk({name, ".aempty"}, {31'd0, almost_empty}, {31'd0, exp_cnt <= 2});
  endtask

  task automatic drive(input logic f, input logic p, input logic [7:0] d,
                       input logic r, input logic c);
    flush = f; push = p; din = d; pop = r; clr_err = c;
    @(posedge clk);
    #1;
    flush = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk_state(name, 0);
    chk({name, ".dout"}, {24'd0, dout}, 32'd0);
    chk({name, ".valid"}, {31'd0, dout_valid}, 32'd0);
    chk({name, ".ovf"}, {31'd0, overflow}, 32'd0);
    chk({name, ".udf"}, {31'd0, underflow}, 32'd0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] exp_w;

    vecs[0]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 2, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 3, 1'b0, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1, 8'h11, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 8'h22, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 8'h33, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h33, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h33, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h33, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h33, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 8'hA0, 1'b1, 1'b0, 1, 1'b0, 8'h33, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 8'hA0, 1'b0};

    rst = 1'b1;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // basic ordering, underflow, clr_err, push+pop at empty
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].flush, vecs[i].push, vecs[i].din, vecs[i].pop, vecs[i].clr_err);
      chk_state($sformatf("vec%0d", i), vecs[i].exp_cnt);
      chk($sformatf("vec%0d.valid", i), {31'd0, dout_valid}, {31'd0, vecs[i].exp_valid});
      chk($sformatf("vec%0d.dout", i), {24'd0, dout}, {24'd0, vecs[i].exp_dout});
      chk($sformatf("vec%0d.udf", i), {31'd0, underflow}, {31'd0, vecs[i].exp_udf & ERR_EN});
      chk($sformatf("vec%0d.ovf", i), {31'd0, overflow}, 32'd0);
    end

    // fill to full, then one push too many
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
      chk_state($sformatf("fill%0d", i), i + 1);
    end
    drive(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    chk_state("overpush", 16);
    chk("overpush.ovf", {31'd0, overflow}, {31'd0, ERR_EN});

    // push+pop at full: only the pop goes through, oldest word comes out
    drive(1'b0, 1'b1, 8'h50, 1'b1, 1'b0);
    chk_state("fullpp", 15);
    chk("fullpp.valid", {31'd0, dout_valid}, 32'd1);
    chk("fullpp.dout", {24'd0, dout}, 32'h40);
    chk("fullpp.ovf", {31'd0, overflow}, {31'd0, ERR_EN});
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr.ovf", {31'd0, overflow}, 32'd0);
    chk("clr.valid", {31'd0, dout_valid}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      chk_state($sformatf("drain%0d", i), 14 - i);
      chk($sformatf("drain%0d.dout", i), {24'd0, dout}, 32'h41 + i);
    end

    // flush at count 9 with push asserted
    drive(1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);
    chk_state("flush", 0);
    chk("flush.valid", {31'd0, dout_valid}, 32'd0);
    chk("flush.dout", {24'd0, dout}, 32'h46);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("postflush.valid", {31'd0, dout_valid}, 32'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // 40 words, steady-state simultaneous push+pop at count 5
    q.delete();
    for (int c = 0; c < 45; c++) begin
      logic p, r;
      p = (c < 40);
      r = (c >= 5);
      exp_w = 8'h80 + 8'(c);
      drive(1'b0, p, exp_w, r, 1'b0);
      if (p) q.push_back(exp_w);
      chk_state($sformatf("stream%0d", c), (c < 5) ? c + 1 : ((c < 40) ? 5 : 44 - c));
      chk($sformatf("stream%0d.valid", c), {31'd0, dout_valid}, {31'd0, r});
      if (r) begin
        exp_w = q.pop_front();
        chk($sformatf("stream%0d.dout", c), {24'd0, dout}, {24'd0, exp_w});
      end
    end

    // asynchronous reset mid-stream
    drive(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'h5B, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("prerst.dout", {24'd0, dout}, 32'h5A);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("prerst.ovf", {31'd0, overflow}, 32'd0);
    chk("prerst.udf", {31'd0, underflow}, 32'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("prerst.udf2", {31'd0, underflow}, {31'd0, ERR_EN});
    push = 1'b1;
    din = 8'h77;
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("asyncrst");
    @(negedge clk);
    push = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_outputs("afterrst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
